fir_tap_sequencer: RTL and testbench

// - Cycle-accurate controller for ReConf_FirFilter: drives the filter's coefficient-RAM, multiplier and accumulator control inputs.
// - Two jobs: loads a new coefficient set from a valid/ready stream, and runs one RAM-read/MAC pass per 600 kHz sample strobe.
// - Sits between the system-side coefficient source and the filter, replacing hand sequencing of CsnRam/WrnRam/EnMul/EnAddAcc.

---
 rtl/fir_tap_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_fir_tap_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_sequencer.sv
// Coefficient-load and per-sample MAC sequencer driving the ReConf_FirFilter RAM/MUL/ACC controls.
// Optional dropped-strobe counter on oOverrunCnt is enabled by defining FIR_SEQ_OVERRUN_CNT_EN.
module fir_tap_sequencer #(
    parameter int NUM_TAPS     = 10,
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 16,
    parameter int UPD_HOLD_CYC = 2
) (
    input  logic              iClk12M,
    input  logic              iRsn,
    input  logic              iEnSample600k,
    input  logic              iCoeffLoadReq,
    input  logic              iCoeffValid,
    input  logic [DATA_W-1:0] iCoeffData,
    output logic              oCoeffReady,
    output logic              oCoeffUpdateFlag,
    output logic              oCsnRam,
    output logic              oWrnRam,
    output logic [ADDR_W-1:0] oAddrRam,
    output logic [DATA_W-1:0] oWtDtRam,
    output logic              oEnMul,
    output logic              oEnAddAcc,
    output logic              oBusy,
    output logic              oRunDone,
    output logic              oCoeffDone,
    output logic              oOverrun,
    output logic [7:0]        oOverrunCnt
);

    localparam logic [ADDR_W-1:0] LAST_TAP  = ADDR_W'(NUM_TAPS - 1);
    localparam logic [ADDR_W-1:0] LAST_HOLD = ADDR_W'(UPD_HOLD_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UPD_SETUP,
        S_UPD_WRITE,
        S_UPD_HOLD,
        S_RD_RUN,
        S_RD_DRAIN1,
        S_RD_DRAIN2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rd_last_q, rd_last_d;
    logic              pend_q, pend_d;

    logic              ready_q, ready_d;
    logic              flag_q, flag_d;
    logic              csn_q, csn_d;
    logic              wrn_q, wrn_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wtdt_q, wtdt_d;
    logic              en_mul_q, en_mul_d;
    logic              en_acc_q, en_acc_d;
    logic              busy_q, busy_d;
    logic              run_done_q, run_done_d;
    logic              coeff_done_q, coeff_done_d;
    logic              overrun_q, overrun_d;

    logic accept;
    assign accept = (state_q == S_UPD_WRITE) && ready_q && iCoeffValid;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rd_last_q <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_last_q <= rd_last_d;
            pend_q    <= pend_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_last_d = rd_last_q;
        pend_d    = pend_q | iCoeffLoadReq;
        unique case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                rd_last_d = 1'b0;
                if (iEnSample600k) begin
                    state_d = S_RD_RUN;
                end else if (pend_q || iCoeffLoadReq) begin
                    state_d = S_UPD_SETUP;
                    pend_d  = 1'b0;
                end
            end
            S_UPD_SETUP: begin
                state_d = S_UPD_WRITE;
                cnt_d   = '0;
            end
            S_UPD_WRITE: begin
                if (accept) begin
                    if (cnt_q == LAST_TAP) begin
                        state_d = S_UPD_HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_UPD_HOLD: begin
                if (cnt_q == LAST_HOLD) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RD_RUN: begin
                // The last tap sets a flag instead of incrementing, so the counter never wraps.
                if (rd_last_q) begin
                    state_d = S_RD_DRAIN1;
                end else if (cnt_q == LAST_TAP) begin
                    rd_last_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RD_DRAIN1: state_d = S_RD_DRAIN2;
            S_RD_DRAIN2: state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        csn_d        = 1'b1;
        wrn_d        = 1'b1;
        addr_d       = '0;
        wtdt_d       = '0;
        ready_d      = (state_d == S_UPD_WRITE);
        flag_d       = (state_d == S_UPD_SETUP) || (state_d == S_UPD_WRITE) ||
                       (state_d == S_UPD_HOLD);
        busy_d       = (state_d != S_IDLE);
        en_mul_d     = !csn_q && wrn_q;
        en_acc_d     = en_mul_q;
        run_done_d   = (state_q == S_RD_DRAIN2);
        coeff_done_d = (state_q == S_UPD_HOLD) && (state_d == S_IDLE);
        overrun_d    = iEnSample600k && (state_q != S_IDLE);
        unique case (state_q)
            S_UPD_WRITE: begin
                if (accept) begin
                    csn_d  = 1'b0;
                    wrn_d  = 1'b0;
                    addr_d = cnt_q;
                    wtdt_d = iCoeffData;
                end
            end
            S_RD_RUN: begin
                if (!rd_last_q) begin
                    csn_d  = 1'b0;
                    addr_d = cnt_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            ready_q      <= 1'b0;
            flag_q       <= 1'b0;
            csn_q        <= 1'b1;
            wrn_q        <= 1'b1;
            addr_q       <= '0;
            wtdt_q       <= '0;
            en_mul_q     <= 1'b0;
            en_acc_q     <= 1'b0;
            busy_q       <= 1'b0;
            run_done_q   <= 1'b0;
            coeff_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            ready_q      <= ready_d;
            flag_q       <= flag_d;
            csn_q        <= csn_d;
            wrn_q        <= wrn_d;
            addr_q       <= addr_d;
            wtdt_q       <= wtdt_d;
            en_mul_q     <= en_mul_d;
            en_acc_q     <= en_acc_d;
            busy_q       <= busy_d;
            run_done_q   <= run_done_d;
            coeff_done_q <= coeff_done_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef FIR_SEQ_OVERRUN_CNT_EN
    logic [7:0] ovr_cnt_q, ovr_cnt_d;

    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        if (overrun_d && (ovr_cnt_q != 8'hFF)) begin
            ovr_cnt_d = ovr_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            ovr_cnt_q <= 8'h00;
        end else begin
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign oOverrunCnt = ovr_cnt_q;
`else
    assign oOverrunCnt = 8'h00;
`endif

    assign oCoeffReady      = ready_q;
    assign oCoeffUpdateFlag = flag_q;
    assign oCsnRam          = csn_q;
    assign oWrnRam          = wrn_q;
    assign oAddrRam         = addr_q;
    assign oWtDtRam         = wtdt_q;
    assign oEnMul           = en_mul_q;
    assign oEnAddAcc        = en_acc_q;
    assign oBusy            = busy_q;
    assign oRunDone         = run_done_q;
    assign oCoeffDone       = coeff_done_q;
    assign oOverrun         = overrun_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer: read-pass vector table plus load, reset and overrun sequences.
module tb_fir_tap_sequencer;

    localparam int N      = 10;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;

    logic              clk;
    logic              rst_n;
    logic              strobe;
    logic              load_req;
    logic              coeff_valid;
    logic [DATA_W-1:0] coeff_data;
    logic              coeff_ready;
    logic              upd_flag;
    logic              csn;
    logic              wrn;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wtdt;
    logic              en_mul;
    logic              en_acc;
    logic              busy;
    logic              run_done;
    logic              coeff_done;
    logic              overrun;
    logic [7:0]        overrun_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    fir_tap_sequencer #(
        .NUM_TAPS    (N),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .UPD_HOLD_CYC(2)
    ) dut (
        .iClk12M         (clk),
        .iRsn            (rst_n),
        .iEnSample600k   (strobe),
        .iCoeffLoadReq   (load_req),
        .iCoeffValid     (coeff_valid),
        .iCoeffData      (coeff_data),
        .oCoeffReady     (coeff_ready),
        .oCoeffUpdateFlag(upd_flag),
        .oCsnRam         (csn),
        .oWrnRam         (wrn),
        .oAddrRam        (addr),
        .oWtDtRam        (wtdt),
        .oEnMul          (en_mul),
        .oEnAddAcc       (en_acc),
        .oBusy           (busy),
        .oRunDone        (run_done),
        .oCoeffDone      (coeff_done),
        .oOverrun        (overrun),
        .oOverrunCnt     (overrun_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic              strb;
        logic              csn;
        logic              wrn;
        logic [ADDR_W-1:0] addr;
        logic              en_mul;
        logic              en_acc;
        logic              run_done;
        logic              busy;
    } rd_vec_t;

    rd_vec_t rd_tab [N+5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " csn"}, csn, 1);
        check({tag, " wrn"}, wrn, 1);
        check({tag, " addr"}, addr, 0);
        check({tag, " wtdt"}, wtdt, 0);
        check({tag, " ready"}, coeff_ready, 0);
        check({tag, " flag"}, upd_flag, 0);
        check({tag, " en_mul"}, en_mul, 0);
        check({tag, " en_acc"}, en_acc, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " run_done"}, run_done, 0);
        check({tag, " coeff_done"}, coeff_done, 0);
        check({tag, " overrun"}, overrun, 0);
        check({tag, " overrun_cnt"}, overrun_cnt, 0);
    endtask

    // Row i is the edge k+i, where k is the edge that samples the strobe.
    task automatic run_pass(input string tag);
        for (int i = 0; i < N + 5; i++) begin
            strobe = rd_tab[i].strb;
            tick();
            strobe = 1'b0;
            check($sformatf("%s csn e%0d", tag, i), csn, rd_tab[i].csn);
            check($sformatf("%s wrn e%0d", tag, i), wrn, rd_tab[i].wrn);
            check($sformatf("%s addr e%0d", tag, i), addr, rd_tab[i].addr);
            check($sformatf("%s en_mul e%0d", tag, i), en_mul, rd_tab[i].en_mul);
            check($sformatf("%s en_acc e%0d", tag, i), en_acc, rd_tab[i].en_acc);
            check($sformatf("%s run_done e%0d", tag, i), run_done, rd_tab[i].run_done);
            check($sformatf("%s busy e%0d", tag, i), busy, rd_tab[i].busy);
        end
    endtask

    // Observation index 0 is the edge at which the update flag first rises.
    task automatic run_load(input string tag, input bit do_req, input bit gapped, input int exp_flag);
        int sent = 0;
        int nwr = 0;
        int nflag = 0;
        int ndone = 0;
        bit acc_prev = 1'b0;
        if (do_req) begin
            load_req = 1'b1;
            tick();
            load_req = 1'b0;
        end
        for (int cyc = 0; cyc < 60 && ndone == 0; cyc++) begin
            if (upd_flag) nflag++;
            if (coeff_done) ndone++;
            check($sformatf("%s csn c%0d", tag, cyc), csn, !acc_prev);
            if (!gapped) check($sformatf("%s ready c%0d", tag, cyc), coeff_ready, (cyc >= 1 && cyc <= N));
            if (acc_prev) begin
                check($sformatf("%s wrn w%0d", tag, nwr), wrn, 0);
                check($sformatf("%s addr w%0d", tag, nwr), addr, nwr);
                check($sformatf("%s data w%0d", tag, nwr), wtdt, 16'ha00 + 16'(nwr));
                nwr++;
            end
            if (ndone == 0) begin
                coeff_valid = (sent < N) && (!gapped || (cyc % 2 == 1));
                coeff_data  = 16'ha00 + 16'(sent);
                acc_prev    = coeff_valid && coeff_ready;
                if (acc_prev) sent++;
                tick();
            end
        end
        coeff_valid = 1'b0;
        coeff_data  = '0;
        check({tag, " done pulses"}, ndone, 1);
        check({tag, " writes"}, nwr, N);
        check({tag, " flag cycles"}, nflag, exp_flag);
        tick();
        check({tag, " done single"}, coeff_done, 0);
        check({tag, " idle busy"}, busy, 0);
        check({tag, " idle flag"}, upd_flag, 0);
    endtask

    initial begin
        int drops;
        int exp_cnt;
        bit exp_ov;

        for (int i = 0; i < N + 5; i++) begin
            rd_tab[i].strb     = (i == 0);
            rd_tab[i].csn      = !(i >= 1 && i <= N);
            rd_tab[i].wrn      = 1'b1;
            rd_tab[i].addr     = (i >= 1 && i <= N) ? ADDR_W'(i - 1) : '0;
            rd_tab[i].en_mul   = (i >= 2 && i <= N + 1);
            rd_tab[i].en_acc   = (i >= 3 && i <= N + 2);
            rd_tab[i].run_done = (i == N + 3);
            rd_tab[i].busy     = (i <= N + 2);
        end

        rst_n       = 1'b0;
        strobe      = 1'b0;
        load_req    = 1'b0;
        coeff_valid = 1'b0;
        coeff_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        tick();
        tick();

        run_pass("pass1");
        run_load("load_const", 1'b1, 1'b0, 13);
        run_load("load_gap", 1'b1, 1'b1, 22);

        // Strobe and load request together: the pass runs first, load follows oRunDone.
        strobe   = 1'b1;
        load_req = 1'b1;
        tick();
        strobe   = 1'b0;
        load_req = 1'b0;
        for (int e = 0; e <= N + 3; e++) begin
            if (e > 0) tick();
            check($sformatf("both flag e%0d", e), upd_flag, 0);
        end
        check("both run_done", run_done, 1);
        tick();
        check("both flag start", upd_flag, 1);
        check("both busy start", busy, 1);
        run_load("load_after", 1'b0, 1'b0, 13);

        // Reset mid-pass.
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        repeat (4) tick();
        check("midpass busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        run_pass("pass2");

        // Strobes spaced 5 clocks: every third one starts a pass, the rest are dropped.
        drops = 0;
        for (int i = 0; i < 390; i++) begin
            strobe = 1'b1;
            tick();
            strobe = 1'b0;
            exp_ov = (i % 3 != 0);
            if (exp_ov) drops++;
            check($sformatf("ovr pulse s%0d", i), overrun, exp_ov);
`ifdef FIR_SEQ_OVERRUN_CNT_EN
            exp_cnt = (drops > 255) ? 255 : drops;
`else
            exp_cnt = 0;
`endif
            check($sformatf("ovr cnt s%0d", i), overrun_cnt, exp_cnt);
            tick();
            if (i < 6) check($sformatf("ovr pulse end s%0d", i), overrun, 0);
            repeat (3) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
